dct8x8_stream: RTL and testbench
================================

# dct8x8_stream

Streaming, parametrised 8x8 two-dimensional forward DCT engine for the image-processing datapath. It accepts one 8x8 block of samples over a valid/ready input port in raster order, then runs a row pass and a column pass on a single time-multiplexed 8-point butterfly. It returns 64 coefficients over a valid/ready output port with backpressure. It sits between the pixel source and the quantiser/display stages, and replaces fixed-table, free-running DCT blocks.

## Interface
- IN_W, 8: input sample width (unsigned).
- OUT_W, 12: output coefficient width (signed two's complement).
- INT_W, 16: signed width of the row-pass results held in the transpose store.
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a sample; high only in state LOAD.
- in_data  input  IN_W  pixel sample, raster order (row 0 col 0 first).
- out_valid  output  1  out_data holds a coefficient.
- out_ready  input  1  downstream accepts a coefficient.
- out_data  output  OUT_W  coefficient F(v,u), emitted in raster order as index v*8+u.
- out_last  output  1  high with coefficient 63.
- busy  output  1  high in states ROW, COL and OUT.

## Operation
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, state=LOAD, and all indices are 0. Sample and transpose storage are not cleared.
- LOAD: a handshake occurs when in_valid and in_ready are both high. Each handshake writes the sample at load index n (0..63), then increments n. After the handshake at n=63, the state moves to ROW.
- ROW: lasts 8 cycles. In each cycle r, the block computes 8 outputs of row r and writes them to the transpose store at [r][k].
- COL: lasts 8 cycles. In each cycle c, the block computes 8 outputs of column c from the transpose store and writes them to the coefficient store at [k][c].
- OUT: out_valid is held high. Each handshake (out_valid and out_ready both high) advances the output index. After the handshake at index 63, the state returns to LOAD.
- In every state other than LOAD, in_valid is ignored and no sample is stored.
- The 1-D kernel is the standard 8-point even/odd DCT. Constants are unsigned, with 12 fractional bits:
  - a=1448
  - b=2008
  - c=1892
  - d=1702
  - e=1137
  - f=783
  - g=399
- Row and column outputs use the same form. Example: X0 = a*(sum of x0..x7). X1 = b*(x0-x7) + d*(x1-x6) + e*(x2-x5) + g*(x3-x4). X2..X7 use the same sign pattern and constant assignment as the classic Chen factorisation.
- Arithmetic rules:
  - Products and sums are signed, with at least IN_W+17 bits in the row pass and INT_W+17 bits in the column pass.
  - Each result is rounded by adding 2048, then arithmetic-shifting right by 12 (floor).
  - Row results saturate to signed INT_W.
  - Column results saturate to signed OUT_W, with range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Reset asserted in any state aborts the block. The partial block is discarded, and the block shows reset values on the next cycle.

## Timing
- Let T be the cycle of the input handshake at n=63.
  - ROW occupies T+1..T+8.
  - COL occupies T+9..T+16.
  - out_valid rises at T+17, carrying coefficient 0.
- With out_ready held high, the block emits one coefficient per cycle. Coefficient 63 (with out_last high) appears at T+80, and in_ready rises at T+81.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable.
- in_ready is registered and equals (state==LOAD). No sample is accepted in the cycle the state leaves LOAD.
- Throughput is one block per 64 input cycles + 16 compute cycles + 64 output cycles, minimum.

## Configuration
- DCT_LEVEL_SHIFT_EN defined: each accepted sample has 2^(IN_W-1) subtracted (JPEG level shift) before the row pass. The input is treated as signed IN_W+1 bits.
- DCT_LEVEL_SHIFT_EN undefined: samples are zero-extended unsigned values.

## Test plan
- Default parameters, DCT_LEVEL_SHIFT_EN defined, all samples 255, out_ready=1 -> F(0,0)=1015, all other 63 coefficients 0, out_last high only on index 63.
- Same configuration, all samples 0 -> F(0,0)=-1024, all others 0.
- DCT_LEVEL_SHIFT_EN undefined, all samples 255 -> F(0,0)=2039, others 0. The first out_valid arrives exactly 17 cycles after the last input handshake.
- IN_W=10, OUT_W=12, no level shift, all samples 1023 -> F(0,0) saturates to 2047, others 0.
- Backpressure: drop out_ready for 5 cycles while index 3 is presented -> out_data holds index 3's value. No coefficient is skipped or duplicated, and in_ready stays 0 until index 63 is accepted. in_valid pulsed during COL -> ignored.
- Reset pulled low for 1 cycle mid-COL -> next cycle in_ready=1, out_valid=0, busy=0. A fresh all-255 block then produces the correct result from the first scenario.

Source files
------------

// File: rtl/dct8x8_stream.sv
// dct8x8_stream: streaming 8x8 2-D forward DCT using one time-multiplexed
// 8-point butterfly. The row pass goes from the sample store to the transpose
// store. The column pass goes from the transpose store to the coefficient store.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   in_valid/in_ready    sample handshake; in_ready is high only while loading
//   in_data[IN_W]        unsigned pixel sample, raster order
//   out_valid/out_ready  coefficient handshake with backpressure
//   out_data[OUT_W]      signed coefficient F(v,u), raster order v*8+u
//   out_last             high with coefficient 63
//   busy                 high while transforming or emitting
//
// Build option: define DCT_LEVEL_SHIFT_EN to subtract 2^(IN_W-1) from every
// accepted sample (JPEG level shift). Without it, samples are zero-extended.
module dct8x8_stream #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12,
  parameter int INT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  localparam int SW = IN_W + 1;
  localparam int XW = (INT_W > SW) ? INT_W : SW;
  localparam int AW = XW + 18;

  localparam logic signed [AW-1:0] CA  = AW'(1448);
  localparam logic signed [AW-1:0] CB  = AW'(2008);
  localparam logic signed [AW-1:0] CC  = AW'(1892);
  localparam logic signed [AW-1:0] CD  = AW'(1702);
  localparam logic signed [AW-1:0] CE  = AW'(1137);
  localparam logic signed [AW-1:0] CF  = AW'(783);
  localparam logic signed [AW-1:0] CG  = AW'(399);
  localparam logic signed [AW-1:0] RND = AW'(2048);

  localparam logic signed [AW-1:0] ROW_MAX = {{(AW-INT_W+1){1'b0}}, {(INT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] ROW_MIN = {{(AW-INT_W+1){1'b1}}, {(INT_W-1){1'b0}}};
  localparam logic signed [AW-1:0] COL_MAX = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] COL_MIN = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_t;

  state_t           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic signed [SW-1:0]    sample_mem [64];
  logic signed [INT_W-1:0] tr_mem     [64];
  logic signed [OUT_W-1:0] coef_mem   [64];

  logic signed [SW-1:0]    sample_in;
  logic signed [AW-1:0]    x   [8];
  logic signed [AW-1:0]    acc [8];
  logic signed [AW-1:0]    rnd [8];
  logic signed [INT_W-1:0] row_res [8];
  logic signed [OUT_W-1:0] col_res [8];
  logic signed [AW-1:0]    s07, s16, s25, s34, d07, d16, d25, d34;

`ifdef DCT_LEVEL_SHIFT_EN
  assign sample_in = $signed({1'b0, in_data}) - $signed({2'b01, {(IN_W-1){1'b0}}});
`else
  assign sample_in = $signed({1'b0, in_data});
`endif

  // One butterfly serves both passes. The row pass reads sample row idx[2:0].
  // The column pass reads transpose column idx[2:0].
  always_comb begin
    for (int unsigned k = 0; k < 8; k++) begin
      if (state_q == COL) begin
        x[k] = AW'(tr_mem[{k[2:0], idx_q[2:0]}]);
      end else begin
        x[k] = AW'(sample_mem[{idx_q[2:0], k[2:0]}]);
      end
    end
  end

  always_comb begin
    s07 = x[0] + x[7];
    s16 = x[1] + x[6];
    s25 = x[2] + x[5];
    s34 = x[3] + x[4];
    d07 = x[0] - x[7];
    d16 = x[1] - x[6];
    d25 = x[2] - x[5];
    d34 = x[3] - x[4];
    acc[0] = CA * (s07 + s16 + s25 + s34);
    acc[4] = CA * (s07 + s34 - s16 - s25);
    acc[2] = CC * (s07 - s34) + CF * (s16 - s25);
    acc[6] = CF * (s07 - s34) - CC * (s16 - s25);
    acc[1] = CB * d07 + CD * d16 + CE * d25 + CG * d34;
    acc[3] = CD * d07 - CG * d16 - CB * d25 - CE * d34;
    acc[5] = CE * d07 - CB * d16 + CG * d25 + CD * d34;
    acc[7] = CG * d07 - CE * d16 + CD * d25 - CB * d34;
    for (int unsigned k = 0; k < 8; k++) begin
      rnd[k] = (acc[k] + RND) >>> 12;
      if (rnd[k] > ROW_MAX) begin
        row_res[k] = ROW_MAX[INT_W-1:0];
      end else if (rnd[k] < ROW_MIN) begin
        row_res[k] = ROW_MIN[INT_W-1:0];
      end else begin
        row_res[k] = rnd[k][INT_W-1:0];
      end
      if (rnd[k] > COL_MAX) begin
        col_res[k] = COL_MAX[OUT_W-1:0];
      end else if (rnd[k] < COL_MIN) begin
        col_res[k] = COL_MIN[OUT_W-1:0];
      end else begin
        col_res[k] = rnd[k][OUT_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) state_d = ROW;
        end
      end
      ROW: begin
        idx_d = idx_q + 6'd1;
        if (idx_q[2:0] == 3'd7) begin
          state_d = COL;
          idx_d   = '0;
        end
      end
      COL: begin
        idx_d = idx_q + 6'd1;
        if (idx_q[2:0] == 3'd7) begin
          // Coefficient 0 was written in the first column cycle, so it can be
          // preloaded now and out_valid rises with valid data.
          state_d    = OUT;
          idx_d      = '0;
          out_data_d = coef_mem[0];
        end
      end
      OUT: begin
        if (out_ready) begin
          if (idx_q == 6'd63) begin
            state_d    = LOAD;
            idx_d      = '0;
            out_data_d = '0;
          end else begin
            idx_d      = idx_q + 6'd1;
            out_data_d = coef_mem[idx_q + 6'd1];
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == LOAD && in_valid) sample_mem[idx_q] <= sample_in;
      if (state_q == ROW) begin
        for (int unsigned k = 0; k < 8; k++) tr_mem[{idx_q[2:0], k[2:0]}] <= row_res[k];
      end
      if (state_q == COL) begin
        for (int unsigned k = 0; k < 8; k++) coef_mem[{k[2:0], idx_q[2:0]}] <= col_res[k];
      end
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != LOAD);
  assign out_last  = (state_q == OUT) && (idx_q == 6'd63);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_dct8x8_stream.sv
module tb_dct8x8_stream;
`ifdef DCT_LEVEL_SHIFT_EN
  localparam bit LS = 1'b1;
`else
  localparam bit LS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_data = '0;
  logic [9:0]  in_data10 = '0;
  logic        in_ready, out_valid, out_last, busy;
  logic        in_ready_10, out_valid_10, out_last_10, busy_10;
  logic [11:0] out_data, out_data_10;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int t_last = 0;
  int first_cyc;
  int n_got;
  int early_ready;
  bit send_to;
  bit coll_to;
  logic [9:0]         blk [64];
  longint             exp8 [64];
  longint             exp10 [64];
  logic signed [11:0] got8 [64];
  logic signed [11:0] got10 [64];
  logic [1:0]         got_last [64];
  int                 got_cyc [64];
  logic [11:0]        stall_d [8];
  logic               stall_l [8];

  dct8x8_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  dct8x8_stream #(.IN_W(10), .OUT_W(12), .INT_W(16)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_10),
    .in_data(in_data10), .out_valid(out_valid_10), .out_ready(out_ready),
    .out_data(out_data_10), .out_last(out_last_10), .busy(busy_10)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DCT-II basis value 0.5*cos(m*pi/16) in Q12; the DC row uses cos(pi/4)/2.
  function automatic longint basis(input int u, input int n);
    longint tbl [9];
    int m;
    tbl = '{0, 2008, 1892, 1702, 1448, 1137, 783, 399, 0};
    if (u == 0) return 1448;
    m = ((2 * n + 1) * u) % 32;
    if (m > 16) m = 32 - m;
    if (m > 8) return -tbl[16 - m];
    return tbl[m];
  endfunction

  function automatic longint rnd_sat(input longint v, input int w);
    longint r, mx, mn;
    r  = (v + 2048) >>> 12;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    if (r > mx) return mx;
    if (r < mn) return mn;
    return r;
  endfunction

  task automatic compute_expected();
    longint x8 [64], x10 [64], t8 [64], t10 [64];
    longint a8, a10;
    for (int n = 0; n < 64; n++) begin
      x8[n]  = longint'(blk[n][7:0]) - (LS ? 128 : 0);
      x10[n] = longint'(blk[n]) - (LS ? 512 : 0);
    end
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        a8 = 0; a10 = 0;
        for (int n = 0; n < 8; n++) begin
          a8  += basis(k, n) * x8[r * 8 + n];
          a10 += basis(k, n) * x10[r * 8 + n];
        end
        t8[r * 8 + k]  = rnd_sat(a8, 16);
        t10[r * 8 + k] = rnd_sat(a10, 16);
      end
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 8; k++) begin
        a8 = 0; a10 = 0;
        for (int r = 0; r < 8; r++) begin
          a8  += basis(k, r) * t8[r * 8 + c];
          a10 += basis(k, r) * t10[r * 8 + c];
        end
        exp8[k * 8 + c]  = rnd_sat(a8, 12);
        exp10[k * 8 + c] = rnd_sat(a10, 12);
      end
  endtask

  // Drives one block with random valid gaps; t_last is the cycle of the last handshake.
  task automatic send_block();
    int n = 0;
    int guard = 0;
    while (n < 64 && guard < 500) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = blk[n][7:0];
      in_data10 = blk[n];
      if (in_valid && in_ready) begin
        if (n == 63) t_last = cyc;
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    send_to = (n < 64);
  endtask

  task automatic collect(input int stall_idx, input int stall_len);
    int guard = 0;
    int stalled = 0;
    n_got = 0; early_ready = 0; first_cyc = -1;
    while (n_got < 64 && guard < 400) begin
      if (in_ready) early_ready++;
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && n_got == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        stall_d[stalled] = out_data;
        stall_l[stalled] = out_last;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got8[n_got]     = out_data;
        got10[n_got]    = out_data_10;
        got_last[n_got] = {out_last, out_last_10};
        got_cyc[n_got]  = cyc;
        n_got++;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    coll_to = (n_got < 64);
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", out_valid); else passed++;
    checks++; if (out_data !== 12'd0) $display("FAIL reset_out_data got %0d expected 0", out_data); else passed++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b expected 0", out_last); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else passed++;
    checks++; if ({in_ready_10, out_valid_10, busy_10} !== 3'b100)
      $display("FAIL reset_dut10 got %b expected 100", {in_ready_10, out_valid_10, busy_10}); else passed++;
  endtask

  task automatic test_const_blocks();
    logic [9:0] pats [3];
    pats = '{10'd255, 10'd0, 10'd1023};
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 64; n++) blk[n] = pats[p];
      compute_expected();
      send_block();
      checks++; if (send_to) $display("FAIL const_send_timeout pattern %0d got %0b expected 0", p, send_to); else passed++;
      collect(-1, 0);
      checks++; if (coll_to) $display("FAIL const_collect_timeout got %0d coefs expected 64", n_got); else passed++;
      checks++; if (first_cyc !== t_last + 17) $display("FAIL const_first_latency got %0d expected %0d", first_cyc - t_last, 17); else passed++;
      checks++; if (got_cyc[63] !== t_last + 80) $display("FAIL const_last_latency got %0d expected %0d", got_cyc[63] - t_last, 80); else passed++;
      checks++; if (in_ready !== 1'b1 || cyc !== t_last + 81)
        $display("FAIL const_ready_return got in_ready=%b at +%0d expected 1 at +81", in_ready, cyc - t_last); else passed++;
      checks++; if (early_ready !== 0) $display("FAIL const_early_ready got %0d expected 0", early_ready); else passed++;
      for (int i = 0; i < 64; i++) begin
        checks++; if (longint'(got8[i]) !== exp8[i]) $display("FAIL const%0d_coef8[%0d] got %0d expected %0d", p, i, got8[i], exp8[i]); else passed++;
        checks++; if (longint'(got10[i]) !== exp10[i]) $display("FAIL const%0d_coef10[%0d] got %0d expected %0d", p, i, got10[i], exp10[i]); else passed++;
        checks++; if (got_last[i] !== {2{i == 63}}) $display("FAIL const%0d_last[%0d] got %b expected %b", p, i, got_last[i], {2{i == 63}}); else passed++;
      end
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 3; b++) begin
      for (int n = 0; n < 64; n++) blk[n] = 10'($urandom);
      compute_expected();
      send_block();
      checks++; if (send_to) $display("FAIL rand_send_timeout got %0b expected 0", send_to); else passed++;
      collect(-1, 0);
      checks++; if (coll_to) $display("FAIL rand_collect_timeout got %0d coefs expected 64", n_got); else passed++;
      for (int i = 0; i < 64; i++) begin
        checks++; if (longint'(got8[i]) !== exp8[i]) $display("FAIL rand%0d_coef8[%0d] got %0d expected %0d", b, i, got8[i], exp8[i]); else passed++;
        checks++; if (longint'(got10[i]) !== exp10[i]) $display("FAIL rand%0d_coef10[%0d] got %0d expected %0d", b, i, got10[i], exp10[i]); else passed++;
        checks++; if (got_last[i] !== {2{i == 63}}) $display("FAIL rand%0d_last[%0d] got %b expected %b", b, i, got_last[i], {2{i == 63}}); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 64; n++) blk[n] = 10'($urandom);
    compute_expected();
    send_block();
    checks++; if (send_to) $display("FAIL bp_send_timeout got %0b expected 0", send_to); else passed++;
    // Valid pulses while the column pass runs must not be accepted.
    while (cyc < t_last + 13) begin
      if (cyc >= t_last + 9) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1)
          $display("FAIL bp_col_ready got in_ready=%b busy=%b expected 0/1", in_ready, busy); else passed++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    collect(3, 5);
    checks++; if (coll_to) $display("FAIL bp_collect_timeout got %0d coefs expected 64", n_got); else passed++;
    checks++; if (early_ready !== 0) $display("FAIL bp_early_ready got %0d expected 0", early_ready); else passed++;
    for (int s = 0; s < 5; s++) begin
      checks++; if (stall_d[s] !== got8[3] || stall_l[s] !== 1'b0)
        $display("FAIL bp_hold[%0d] got %0d/%b expected %0d/0", s, stall_d[s], stall_l[s], got8[3]); else passed++;
    end
    for (int i = 0; i < 64; i++) begin
      checks++; if (longint'(got8[i]) !== exp8[i]) $display("FAIL bp_coef8[%0d] got %0d expected %0d", i, got8[i], exp8[i]); else passed++;
      checks++; if (got_last[i] !== {2{i == 63}}) $display("FAIL bp_last[%0d] got %b expected %b", i, got_last[i], {2{i == 63}}); else passed++;
    end
    checks++; if (got_cyc[63] !== t_last + 85) $display("FAIL bp_last_cycle got %0d expected %0d", got_cyc[63] - t_last, 85); else passed++;
  endtask

  task automatic test_reset_mid_col();
    for (int n = 0; n < 64; n++) blk[n] = 10'($urandom);
    send_block();
    checks++; if (send_to) $display("FAIL rst_send_timeout got %0b expected 0", send_to); else passed++;
    while (cyc < t_last + 12) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if ({in_ready, out_valid, busy, out_last} !== 4'b1000)
      $display("FAIL rst_mid_col got rdy/vld/busy/last=%b expected 1000", {in_ready, out_valid, busy, out_last}); else passed++;
    for (int n = 0; n < 64; n++) blk[n] = 10'd255;
    compute_expected();
    send_block();
    checks++; if (send_to) $display("FAIL rst_fresh_send_timeout got %0b expected 0", send_to); else passed++;
    collect(-1, 0);
    checks++; if (coll_to) $display("FAIL rst_collect_timeout got %0d coefs expected 64", n_got); else passed++;
    for (int i = 0; i < 64; i++) begin
      checks++; if (longint'(got8[i]) !== exp8[i]) $display("FAIL rst_coef8[%0d] got %0d expected %0d", i, got8[i], exp8[i]); else passed++;
      checks++; if (longint'(got10[i]) !== exp10[i]) $display("FAIL rst_coef10[%0d] got %0d expected %0d", i, got10[i], exp10[i]); else passed++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_const_blocks();
    test_random();
    test_backpressure();
    test_reset_mid_col();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
